// File: rtl/db_access_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | db_access_sequencer_pkg : state/command types and command decode   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package db_access_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HALT_WAIT = 3'd1,
      MEM_REQ   = 3'd2,
      MEM_WAIT  = 3'd3,
      RF_ACC    = 3'd4,
      RF_CAP    = 3'd5,
      RST_PULSE = 3'd6,
      DONE      = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE = 3'd0,
      MEM_WR   = 3'd1,
      REG_WR   = 3'd2,
      MEM_RD   = 3'd3,
      REG_RD   = 3'd4,
      PAUSE    = 3'd5,
      RESUME   = 3'd6,
      RESET    = 3'd7
   } cmd_t;

   // Several decode bits may be set at once; the highest-priority one wins.
   function automatic cmd_t decode_cmd(
      input logic mem_wr,
      input logic reg_wr,
      input logic mem_rd,
      input logic reg_rd,
      input logic pause,
      input logic resume,
      input logic reset
   );
      cmd_t c;
      if (mem_wr)      c = MEM_WR;
      else if (reg_wr) c = REG_WR;
      else if (mem_rd) c = MEM_RD;
      else if (reg_rd) c = REG_RD;
      else if (pause)  c = PAUSE;
      else if (resume) c = RESUME;
      else if (reset)  c = RESET;
      else             c = CMD_NONE;
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/db_access_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | db_access_sequencer_if : command/response bus from mcu_controller  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface db_access_sequencer_if;
   logic        valid;
   logic        pause;
   logic        resume;
   logic        reset;
   logic        reg_rd;
   logic        reg_wr;
   logic        mem_rd;
   logic        mem_wr;
   logic [3:0]  mem_be;
   logic [31:0] addr;
   logic [31:0] d_in;
   logic        mcu_busy;
   logic [31:0] d_rd;
   logic        error;

   modport master (
      output valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr,
      output mem_be, addr, d_in,
      input  mcu_busy, d_rd, error
   );

   modport slave (
      input  valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr,
      input  mem_be, addr, d_in,
      output mcu_busy, d_rd, error
   );
endinterface
`default_nettype wire

// File: rtl/db_access_sequencer_timeout.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | db_timeout : clearable up-counter that saturates at LIMIT          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module db_timeout #(
   parameter int LIMIT = 1024,
   parameter int CNT_W = $clog2(LIMIT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             expired
);
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign expired = (count_q == CNT_W'(LIMIT));
   assign count   = count_q;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = '0;
      else if (en && !expired)
         count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end
endmodule
`default_nettype wire

// File: rtl/db_access_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | db_access_sequencer : debugger command sequencer and arbiter for   |
// | the shared memory port / register file.  Rev 1.0                   |
// +--------------------------------------------------------------------+
module db_access_sequencer
   import db_access_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int RESET_CYCLES   = 4,
   parameter int RF_ADDR_W      = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   db_access_sequencer_if.slave ctl,
   output logic                 cpu_pause,
   input  logic                 cpu_halted,
   output logic                 cpu_rst,
   input  logic                 core_mem_req,
   input  logic                 core_mem_we,
   input  logic [3:0]           core_mem_be,
   input  logic [31:0]          core_mem_addr,
   input  logic [31:0]          core_mem_wdata,
   output logic                 core_mem_ack,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [3:0]           mem_be,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   input  logic [31:0]          mem_rdata,
   input  logic                 mem_ack,
   output logic                 rf_we,
   output logic [RF_ADDR_W-1:0] rf_addr,
   output logic [31:0]          rf_wdata,
   input  logic [31:0]          rf_rdata
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t      state_q, state_d;
   cmd_t        cmd_q, cmd_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        paused_q, paused_d;
   logic        auto_q, auto_d;
   logic        cpu_pause_q, cpu_pause_d;
   logic [31:0] d_rd_q, d_rd_d;
   logic        error_q, error_d;

   logic             tmo_load;
   logic             tmo_en;
   logic [CNT_W-1:0] tmo_count;
   logic             tmo_expired;
   logic             own;
   logic             rf_we_c;
   logic [31:0]      rf_wdata_c;
   logic [RF_ADDR_W-1:0] rf_addr_c;

   db_timeout #(
      .LIMIT (TIMEOUT_CYCLES),
      .CNT_W (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .load    (tmo_load),
      .en      (tmo_en),
      .count   (tmo_count),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      be_d        = be_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      paused_d    = paused_q;
      auto_d      = auto_q;
      cpu_pause_d = cpu_pause_q;
      d_rd_d      = d_rd_q;
      error_d     = ctl.valid && (state_q != IDLE);
      tmo_load    = 1'b0;
      tmo_en      = 1'b0;
      own         = 1'b0;
      rf_we_c     = 1'b0;
      rf_addr_c   = '0;
      rf_wdata_c  = '0;

      case (state_q)
         IDLE: begin
            if (ctl.valid) begin
               cmd_d   = decode_cmd(ctl.mem_wr, ctl.reg_wr, ctl.mem_rd, ctl.reg_rd,
                                    ctl.pause, ctl.resume, ctl.reset);
               be_d    = ctl.mem_be;
               addr_d  = ctl.addr;
               wdata_d = ctl.d_in;
               case (cmd_d)
                  CMD_NONE: state_d = DONE;
                  PAUSE: begin
                     if (paused_q) begin
                        state_d = DONE;
                     end else begin
                        cpu_pause_d = 1'b1;
                        tmo_load    = 1'b1;
                        state_d     = HALT_WAIT;
                     end
                  end
                  RESUME: begin
                     cpu_pause_d = 1'b0;
                     paused_d    = 1'b0;
                     state_d     = DONE;
                  end
                  RESET: begin
                     tmo_load = 1'b1;
                     state_d  = RST_PULSE;
                  end
                  default: begin
                     // Running core: halt it just for this one access.
                     if (!paused_q) begin
                        auto_d      = 1'b1;
                        cpu_pause_d = 1'b1;
                        tmo_load    = 1'b1;
                        state_d     = HALT_WAIT;
                     end else if (cmd_d == MEM_WR || cmd_d == MEM_RD) begin
                        state_d = MEM_REQ;
                     end else begin
                        state_d = RF_ACC;
                     end
                  end
               endcase
            end
         end

         HALT_WAIT: begin
            tmo_en = 1'b1;
            if (cpu_halted) begin
               if (cmd_q == PAUSE) begin
                  paused_d = 1'b1;
                  state_d  = DONE;
               end else if (cmd_q == MEM_WR || cmd_q == MEM_RD) begin
                  state_d = MEM_REQ;
               end else begin
                  state_d = RF_ACC;
               end
            end else if (tmo_expired) begin
               error_d = 1'b1;
               if (auto_q) begin
                  cpu_pause_d = 1'b0;
                  auto_d      = 1'b0;
               end
               state_d = IDLE;
            end
         end

         MEM_REQ, MEM_WAIT: begin
            own    = 1'b1;
            tmo_en = (state_q == MEM_WAIT);
            if (mem_ack) begin
               if (cmd_q == MEM_RD)
                  d_rd_d = mem_rdata;
               if (auto_q) begin
                  cpu_pause_d = 1'b0;
                  auto_d      = 1'b0;
               end
               state_d = DONE;
            end else if (state_q == MEM_REQ) begin
               tmo_load = 1'b1;
               state_d  = MEM_WAIT;
            end else if (tmo_expired) begin
               error_d = 1'b1;
               if (auto_q) begin
                  cpu_pause_d = 1'b0;
                  auto_d      = 1'b0;
               end
               state_d = IDLE;
            end
         end

         RF_ACC: begin
            rf_addr_c = addr_q[RF_ADDR_W-1:0];
            if (cmd_q == REG_WR) begin
               // Register 0 is hardwired; the write is dropped but still completes.
               rf_we_c    = |addr_q[RF_ADDR_W-1:0];
               rf_wdata_c = wdata_q;
               if (auto_q) begin
                  cpu_pause_d = 1'b0;
                  auto_d      = 1'b0;
               end
               state_d = DONE;
            end else begin
               state_d = RF_CAP;
            end
         end

         RF_CAP: begin
            d_rd_d = rf_rdata;
            if (auto_q) begin
               cpu_pause_d = 1'b0;
               auto_d      = 1'b0;
            end
            state_d = DONE;
         end

         RST_PULSE: begin
            tmo_en = 1'b1;
            if (tmo_count == CNT_W'(RESET_CYCLES - 1))
               state_d = DONE;
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_q       <= CMD_NONE;
         be_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         paused_q    <= 1'b0;
         auto_q      <= 1'b0;
         cpu_pause_q <= 1'b0;
         d_rd_q      <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         paused_q    <= paused_d;
         auto_q      <= auto_d;
         cpu_pause_q <= cpu_pause_d;
         d_rd_q      <= d_rd_d;
         error_q     <= error_d;
      end
   end

   assign ctl.mcu_busy = ctl.valid | (state_q != IDLE);
   assign ctl.d_rd     = d_rd_q;
   assign ctl.error    = error_q;
   assign cpu_pause    = cpu_pause_q;
   assign cpu_rst      = (state_q == RST_PULSE);

   // Shared port: debugger drives it from MEM_REQ through the ack cycle.
   assign mem_req      = own ? 1'b1              : core_mem_req;
   assign mem_we       = own ? (cmd_q == MEM_WR) : core_mem_we;
   assign mem_be       = own ? be_q              : core_mem_be;
   assign mem_addr     = own ? addr_q            : core_mem_addr;
   assign mem_wdata    = own ? wdata_q           : core_mem_wdata;
   assign core_mem_ack = own ? 1'b0              : mem_ack;

   assign rf_we    = rf_we_c;
   assign rf_addr  = rf_addr_c;
   assign rf_wdata = rf_wdata_c;
endmodule
`default_nettype wire

// File: tb/tb_db_access_sequencer.sv
`default_nettype none
// Scoreboard bench: each command pushes its expected outcome; a monitor checks it when mcu_busy falls.
module tb_db_access_sequencer;
   localparam int TO = 1024;
   localparam int DC = -99;
   localparam logic [6:0] B_NONE   = 7'b0000000;
   localparam logic [6:0] B_MEM_WR = 7'b1000000;
   localparam logic [6:0] B_REG_WR = 7'b0100000;
   localparam logic [6:0] B_MEM_RD = 7'b0010000;
   localparam logic [6:0] B_REG_RD = 7'b0001000;
   localparam logic [6:0] B_PAUSE  = 7'b0000100;
   localparam logic [6:0] B_RESUME = 7'b0000010;
   localparam logic [6:0] B_RESET  = 7'b0000001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   db_access_sequencer_if ctl();
   logic        cpu_pause, cpu_halted, cpu_rst;
   logic        core_mem_req, core_mem_we, core_mem_ack;
   logic [3:0]  core_mem_be;
   logic [31:0] core_mem_addr, core_mem_wdata;
   logic        mem_req, mem_we, mem_ack;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata, rf_rdata;

   db_access_sequencer #(.TIMEOUT_CYCLES(TO), .RESET_CYCLES(4), .RF_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .ctl(ctl),
      .cpu_pause(cpu_pause), .cpu_halted(cpu_halted), .cpu_rst(cpu_rst),
      .core_mem_req(core_mem_req), .core_mem_we(core_mem_we), .core_mem_be(core_mem_be),
      .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata), .core_mem_ack(core_mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- environment models ----------------
   int   ack_delay = 1;
   bit   ack_en    = 1'b1;
   bit   force_ack = 1'b0;
   int   req_cnt   = 0;
   int   halt_delay = 2;
   int   halt_cnt  = 0;
   logic [31:0] mem_model [0:63];
   logic [31:0] rf_model  [0:31];
   logic [31:0] last_ack_addr, last_ack_wdata;
   logic        last_ack_we;

   always @(posedge clk) begin
      #1;
      if (mem_req && ack_en) req_cnt++;
      else                   req_cnt = 0;
      mem_ack   = force_ack || (ack_en && mem_req && req_cnt == ack_delay);
      mem_rdata = force_ack ? 32'h5A5A_5A5A : (mem_ack ? mem_model[mem_addr[7:2]] : 32'h0);
      if (cpu_pause) begin if (halt_cnt < 1000) halt_cnt++; end
      else halt_cnt = 0;
      cpu_halted = cpu_pause && (halt_cnt >= halt_delay);
   end

   always @(negedge clk) begin
      if (mem_req && mem_ack) begin
         last_ack_addr  = mem_addr;
         last_ack_wdata = mem_wdata;
         last_ack_we    = mem_we;
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem_model[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
   end

   always @(posedge clk) begin
      if (rf_we) rf_model[rf_addr] <= rf_wdata;
      rf_rdata <= rf_model[rf_addr];
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] d_rd;
      int errs, pause_end, pause_seen, rfwe, memcyc, rstcyc, ack2idle;
   } exp_t;
   exp_t exp_q[$];

   function automatic exp_t mk(input logic [31:0] d, input int e, input int pe, input int ps,
                               input int rw, input int mc, input int rc, input int ai);
      exp_t x;
      x.d_rd = d; x.errs = e; x.pause_end = pe; x.pause_seen = ps;
      x.rfwe = rw; x.memcyc = mc; x.rstcyc = rc; x.ack2idle = ai;
      return x;
   endfunction

   int cyc = 0, errs = 0, rfwe = 0, memcyc = 0, rstcyc = 0, pseen = 0, ack_cyc = -1;
   bit busy_prev = 1'b0;

   always @(negedge clk) begin
      exp_t x;
      cyc++;
      if (rst) begin
         errs = 0; rfwe = 0; memcyc = 0; rstcyc = 0; pseen = 0; ack_cyc = -1;
         busy_prev = 1'b0;
      end else begin
         if (ctl.error) errs++;
         if (ctl.mcu_busy) begin
            if (rf_we)   rfwe++;
            if (mem_req) memcyc++;
            if (cpu_rst) rstcyc++;
            if (cpu_pause) pseen = 1;
            if (mem_req && mem_ack) ack_cyc = cyc;
         end
         if (busy_prev && !ctl.mcu_busy) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: completion at cycle %0d with empty queue", cyc);
            end else begin
               x = exp_q.pop_front();
               check("d_rd", ctl.d_rd, x.d_rd);
               check("error_pulses", errs, x.errs);
               check("cpu_pause_end", {31'b0, cpu_pause}, x.pause_end);
               if (x.pause_seen != DC) check("cpu_pause_seen", pseen, x.pause_seen);
               check("rf_we_cycles", rfwe, x.rfwe);
               if (x.memcyc != DC) check("mem_req_cycles", memcyc, x.memcyc);
               check("cpu_rst_cycles", rstcyc, x.rstcyc);
               check("ack_to_idle", (ack_cyc < 0) ? -1 : cyc - ack_cyc, x.ack2idle);
            end
            errs = 0; rfwe = 0; memcyc = 0; rstcyc = 0; pseen = 0; ack_cyc = -1;
         end
         busy_prev = ctl.mcu_busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [6:0] bits, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
      @(posedge clk); #1;
      ctl.valid = 1'b1;
      {ctl.mem_wr, ctl.reg_wr, ctl.mem_rd, ctl.reg_rd, ctl.pause, ctl.resume, ctl.reset} = bits;
      ctl.addr = a; ctl.d_in = d; ctl.mem_be = be;
      @(posedge clk); #1;
      ctl.valid = 1'b0;
      {ctl.mem_wr, ctl.reg_wr, ctl.mem_rd, ctl.reg_rd, ctl.pause, ctl.resume, ctl.reset} = B_NONE;
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while (ctl.mcu_busy && n < max) begin @(posedge clk); #1; n++; end
      if (ctl.mcu_busy) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, max);
      end
      @(negedge clk); #1;
   endtask

   task automatic wait_req(input string name, input int max);
      int n = 0;
      while (!mem_req && n < max) begin @(posedge clk); #1; n++; end
      if (!mem_req) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_noreq: mem_req low after %0d cycles, required high", name, max);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
      for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
      ctl.valid = 1'b0;
      {ctl.mem_wr, ctl.reg_wr, ctl.mem_rd, ctl.reg_rd, ctl.pause, ctl.resume, ctl.reset} = B_NONE;
      ctl.addr = '0; ctl.d_in = '0; ctl.mem_be = '0;
      mem_ack = 1'b0; mem_rdata = '0; cpu_halted = 1'b0;
      ack_en = 1'b0;
      core_mem_req = 1'b1; core_mem_we = 1'b1; core_mem_be = 4'h3;
      core_mem_addr = 32'h55; core_mem_wdata = 32'h99;

      // Reset state: outputs idle, port follows the core.
      repeat (2) @(posedge clk); #1;
      check("rst_busy", {31'b0, ctl.mcu_busy}, 0);
      check("rst_d_rd", ctl.d_rd, 0);
      check("rst_error", {31'b0, ctl.error}, 0);
      check("rst_cpu_pause", {31'b0, cpu_pause}, 0);
      check("rst_cpu_rst", {31'b0, cpu_rst}, 0);
      check("rst_rf_we", {31'b0, rf_we}, 0);
      check("rst_mux_req", {31'b0, mem_req}, 1);
      check("rst_mux_addr", mem_addr, 32'h55);
      check("rst_mux_wdata", mem_wdata, 32'h99);
      check("rst_mux_be", {28'b0, mem_be}, 4'h3);
      rst = 1'b0;
      core_mem_req = 1'b0; core_mem_we = 1'b0; core_mem_addr = '0; core_mem_wdata = '0;
      core_mem_be = '0;
      ack_en = 1'b1;

      // pause a running core
      halt_delay = 2;
      exp_q.push_back(mk(32'h0, 0, 1, 1, 0, 0, 0, -1));
      issue(B_PAUSE, 0, 0, 0); wait_idle("pause", 50);

      // paused mem_wr, ack in the 3rd request cycle
      ack_delay = 3;
      exp_q.push_back(mk(32'h0, 0, 1, 1, 0, 3, 0, 2));
      issue(B_MEM_WR, 32'h10, 32'hCAFE_F00D, 4'hF); wait_idle("mem_wr", 50);
      check("wr_addr", last_ack_addr, 32'h10);
      check("wr_wdata", last_ack_wdata, 32'hCAFE_F00D);
      check("wr_we", {31'b0, last_ack_we}, 1);

      // reset command while paused: 4-cycle cpu_rst, stays paused
      exp_q.push_back(mk(32'h0, 0, 1, 1, 0, 0, 4, -1));
      issue(B_RESET, 0, 0, 0); wait_idle("reset_cmd", 50);

      exp_q.push_back(mk(32'h0, 0, 0, DC, 0, 0, 0, -1));
      issue(B_RESUME, 0, 0, 0); wait_idle("resume", 50);

      // running core, mem_rd with auto-pause
      halt_delay = 5; ack_delay = 1;
      exp_q.push_back(mk(32'hCAFE_F00D, 0, 0, 1, 0, 1, 0, 2));
      issue(B_MEM_RD, 32'h10, 0, 4'hF); wait_idle("mem_rd", 50);

      // reg_wr to r0 is dropped
      exp_q.push_back(mk(32'hCAFE_F00D, 0, 0, 1, 0, 0, 0, -1));
      issue(B_REG_WR, 32'h0, 32'h1234, 0); wait_idle("reg_wr0", 50);
      check("rf0_untouched", rf_model[0], 0);

      exp_q.push_back(mk(32'hCAFE_F00D, 0, 0, 1, 1, 0, 0, -1));
      issue(B_REG_WR, 32'h3, 32'hA5, 0); wait_idle("reg_wr3", 50);

      exp_q.push_back(mk(32'hA5, 0, 0, 1, 0, 0, 0, -1));
      issue(B_REG_RD, 32'h3, 0, 0); wait_idle("reg_rd3", 50);

      // mem_wr|pause: only mem_wr runs, so auto-pause is released afterwards
      exp_q.push_back(mk(32'hA5, 0, 0, 1, 0, 1, 0, 2));
      issue(B_MEM_WR | B_PAUSE, 32'h20, 32'h1111_2222, 4'hF); wait_idle("prio", 50);
      exp_q.push_back(mk(32'h1111_2222, 0, 0, 1, 0, 1, 0, 2));
      issue(B_MEM_RD, 32'h20, 0, 4'hF); wait_idle("prio_rd", 50);

      // valid during MEM_WAIT is rejected with an error pulse
      ack_delay = 6;
      exp_q.push_back(mk(32'hCAFE_F00D, 1, 0, 1, 0, 6, 0, 2));
      issue(B_MEM_RD, 32'h10, 0, 4'hF);
      wait_req("reject", 50);
      @(posedge clk); #1;
      issue(B_REG_WR, 32'h5, 32'h77, 0);
      wait_idle("reject", 50);
      ack_delay = 1;
      exp_q.push_back(mk(32'h0, 0, 0, 1, 0, 0, 0, -1));
      issue(B_REG_RD, 32'h5, 0, 0); wait_idle("reg_rd5", 50);
      exp_q.push_back(mk(32'hA5, 0, 0, 1, 0, 0, 0, -1));
      issue(B_REG_RD, 32'h3, 0, 0); wait_idle("reg_rd3b", 50);

      // mem_ack never arrives
      ack_en = 1'b0;
      exp_q.push_back(mk(32'hA5, 1, 0, 1, 0, DC, 0, -1));
      issue(B_MEM_RD, 32'h10, 0, 4'hF); wait_idle("tmo", 3 * TO);
      check("tmo_mem_req", {31'b0, mem_req}, 0);
      check("tmo_cpu_pause", {31'b0, cpu_pause}, 0);
      core_mem_req = 1'b1; core_mem_addr = 32'h44; #1;
      check("tmo_port_core_req", {31'b0, mem_req}, 1);
      check("tmo_port_core_addr", mem_addr, 32'h44);
      core_mem_req = 1'b0; core_mem_addr = '0;

      // async reset while in MEM_WAIT
      issue(B_MEM_WR, 32'h30, 32'hDEAD, 4'hF);
      wait_req("rst_op", 50);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      check("arst_busy", {31'b0, ctl.mcu_busy}, 0);
      check("arst_mem_req", {31'b0, mem_req}, 0);
      check("arst_cpu_pause", {31'b0, cpu_pause}, 0);
      check("arst_rf_we", {31'b0, rf_we}, 0);
      check("arst_d_rd", ctl.d_rd, 0);
      @(posedge clk); #1 rst = 1'b0;
      force_ack = 1'b1;
      @(posedge clk); #2;
      check("late_ack_to_core", {31'b0, core_mem_ack}, 1);
      force_ack = 1'b0;
      repeat (2) @(posedge clk); #2;
      check("late_ack_d_rd", ctl.d_rd, 0);
      check("no_late_write", mem_model[12], 0);
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
